// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - radix-2 shift-add unsigned multiplier, start/clear/done responder
// One multiplier bit retires per clock; the product is held until the initiator clears.
module shift_add_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 opstart,
   input  logic                 opclear,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   result,
   output logic [1:0]           opdone
);

   localparam int CW = $clog2(WIDTH) + 1;

   // State encodings double as the opdone status code.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH:0]     r_p;
   logic [CW-1:0]        r_count;

   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH:0]     w_p_next;
   logic                 w_zero;
   logic                 w_last;

   assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
   assign w_p_next = r_p[0] ? {1'b0, w_sum, r_p[WIDTH-1:1]}
                            : {1'b0, r_p[2*WIDTH:1]};
   assign w_zero   = (multiplicand == '0) || (multiplier == '0);
   assign w_last   = (r_count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_mcand <= '0;
         r_p     <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (opclear) begin
                  r_p <= '0;
               end else if (opstart) begin
                  r_mcand <= multiplicand;
                  r_count <= '0;
                  // A zero operand needs no iterations; report done straight away.
                  if (w_zero) begin
                     r_p     <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_p     <= {{(WIDTH+1){1'b0}}, multiplier};
                     r_state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (opclear) begin
                  r_p     <= '0;
                  r_count <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_p     <= w_p_next;
                  r_count <= r_count + CW'(1);
                  if (w_last) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (opclear) begin
                  r_p     <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign result = r_p[2*WIDTH-1:0];
   assign opdone = r_state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed table-driven bench for shift_add_multiplier
module tb_shift_add_multiplier;

   logic          clk;
   logic          reset_n;
   logic          opstart;
   logic          opclear;
   logic [63:0]   multiplicand;
   logic [63:0]   multiplier;
   logic [127:0]  result;
   logic [1:0]    opdone;

   int passed;
   int total;

   typedef struct {
      string        name;
      logic [63:0]  a;
      logic [63:0]  b;
      logic [127:0] prod;
      int           lat;
   } vec_t;

   vec_t vecs[10];

   shift_add_multiplier #(.WIDTH(64)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .opstart      (opstart),
      .opclear      (opclear),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .result       (result),
      .opdone       (opdone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start, wait for done with a bounded cycle budget, then hold with opstart high and clear.
   task automatic run_vec(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] prod, input int lat);
      int edges;
      int busy_bad;
      multiplicand = a;
      multiplier   = b;
      opstart      = 1'b1;
      tick();
      opstart  = 1'b0;
      edges    = 1;
      busy_bad = 0;
      while (opdone !== 2'b11 && edges < 200) begin
         if (opdone !== 2'b10) busy_bad++;
         tick();
         edges++;
      end
      check({name, " busy"}, 128'(busy_bad), 128'd0);
      check({name, " latency"}, 128'(edges), 128'(lat));
      check({name, " result"}, result, prod);
      opstart      = 1'b1;
      multiplicand = 64'd9;
      multiplier   = 64'd9;
      for (int i = 0; i < 3; i++) tick();
      opstart = 1'b0;
      check({name, " hold result"}, result, prod);
      check({name, " hold opdone"}, 128'(opdone), 128'(2'b11));
      opclear = 1'b1;
      tick();
      opclear = 1'b0;
      check({name, " clear result"}, result, 128'd0);
      check({name, " clear opdone"}, 128'(opdone), 128'(2'b00));
   endtask

   initial begin
      vecs[0] = '{"3x5",       64'd3,                 64'd5,                 128'd15,                                 65};
      vecs[1] = '{"max x max", 64'hFFFFFFFFFFFFFFFF,  64'hFFFFFFFFFFFFFFFF,  128'hFFFFFFFFFFFFFFFE_0000000000000001,   65};
      vecs[2] = '{"0x12345",   64'd0,                 64'd12345,             128'd0,                                  1};
      vecs[3] = '{"7x0",       64'd7,                 64'd0,                 128'd0,                                  1};
      vecs[4] = '{"1x1",       64'd1,                 64'd1,                 128'd1,                                  65};
      vecs[5] = '{"2^63x2",    64'h8000000000000000,  64'd2,                 128'h1_0000000000000000,                 65};
      vecs[6] = '{"max x 2",   64'hFFFFFFFFFFFFFFFF,  64'd2,                 128'h1_FFFFFFFFFFFFFFFE,                 65};
      vecs[7] = '{"2 x max",   64'd2,                 64'hFFFFFFFFFFFFFFFF,  128'h1_FFFFFFFFFFFFFFFE,                 65};
      vecs[8] = '{"6x7",       64'd6,                 64'd7,                 128'd42,                                 65};
      vecs[9] = '{"2^32x2^32", 64'h100000000,         64'h100000000,         128'h1_0000000000000000,                 65};

      passed       = 0;
      total        = 0;
      reset_n      = 1'b0;
      opstart      = 1'b0;
      opclear      = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      tick();
      tick();
      check("reset result", result, 128'd0);
      check("reset opdone", 128'(opdone), 128'(2'b00));
      reset_n = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat);

      // opstart pulsed mid-EXEC with different operands must be ignored.
      begin
         int edges;
         multiplicand = 64'd20;
         multiplier   = 64'd19;
         opstart      = 1'b1;
         tick();
         opstart = 1'b0;
         edges   = 1;
         while (opdone !== 2'b11 && edges < 200) begin
            if (edges == 9) begin
               multiplicand = 64'd9;
               multiplier   = 64'd9;
               opstart      = 1'b1;
            end else begin
               opstart = 1'b0;
            end
            tick();
            edges++;
         end
         opstart = 1'b0;
         check("exec start latency", 128'(edges), 128'd65);
         check("exec start result", result, 128'd380);
         // start and clear together in DONE: clear wins
         opstart = 1'b1;
         opclear = 1'b1;
         tick();
         check("done clr+start opdone", 128'(opdone), 128'(2'b00));
         check("done clr+start result", result, 128'd0);
         opstart = 1'b0;
         opclear = 1'b0;
      end

      // opclear at edge 30 aborts, then a restart computes normally.
      multiplicand = 64'd6;
      multiplier   = 64'd7;
      opstart      = 1'b1;
      tick();
      opstart = 1'b0;
      for (int i = 2; i < 30; i++) tick();
      check("abort pre opdone", 128'(opdone), 128'(2'b10));
      opclear = 1'b1;
      tick();
      opclear = 1'b0;
      check("abort opdone", 128'(opdone), 128'(2'b00));
      check("abort result", result, 128'd0);
      tick();
      check("abort stays idle", 128'(opdone), 128'(2'b00));
      run_vec("restart 6x7", 64'd6, 64'd7, 128'd42, 65);

      // asynchronous reset between edges mid-EXEC
      multiplicand = 64'd3;
      multiplier   = 64'd5;
      opstart      = 1'b1;
      tick();
      opstart = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset opdone", 128'(opdone), 128'(2'b00));
      check("async reset result", result, 128'd0);
      tick();
      reset_n = 1'b1;
      opstart = 1'b1;
      opclear = 1'b1;
      tick();
      check("idle clr+start opdone", 128'(opdone), 128'(2'b00));
      tick();
      check("idle clr+start opdone 2", 128'(opdone), 128'(2'b00));
      opstart = 1'b0;
      opclear = 1'b0;
      tick();
      run_vec("post reset 3x5", 64'd3, 64'd5, 128'd15, 65);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier, radix-2 shift-add, one multiplier bit per clock.
- Responder side of the multiplier start/clear/done handshake. The factorial next-state controller drives opstart/opclear and waits on the done flag.
- Sits beside the factorial controller in the calculator datapath.
- Returns the full 2*WIDTH-bit product and holds it until the initiator clears.

Parameters:
- WIDTH, 64, operand width in bits. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- opstart  input  1  start request, level sampled at clk rising edge.
- opclear  input  1  clear request, level sampled. Has priority over opstart.
- multiplicand  input  WIDTH  operand A, latched on accepted start.
- multiplier  input  WIDTH  operand B, latched on accepted start.
- result  output  2*WIDTH  product. Valid only while opdone==2'b11.
- opdone  output  2  status: 2'b00 idle, 2'b10 busy, 2'b11 done. Bit 0 is the single-bit done seen by the controller.

Behaviour:
- Reset (reset_n=0, async, any state): state=IDLE, result=0, opdone=2'b00, count=0, internal product/multiplicand registers=0.
- Internal registers:
  - mcand[WIDTH-1:0].
  - P[2*WIDTH:0], a product register with 1 carry bit.
  - count[log2(WIDTH):0].
  - result = P[2*WIDTH-1:0].
- States: IDLE (opdone 00), EXEC (opdone 10), DONE (opdone 11). opdone decodes from registered state only.
- IDLE:
  - opclear=1: stay IDLE, zero P.
  - else opstart=1: mcand<=multiplicand, P<={(WIDTH+1)'b0, multiplier}, count<=0, go EXEC.
  - Zero shortcut: if multiplicand==0 or multiplier==0, P<=0 and go directly to DONE. opdone=11 on the next cycle.
- EXEC, each edge:
  - If P[0]=1: P[2W:W] <= P[2W-1:W] + mcand (WIDTH+1-bit sum, carry kept).
  - Then P <= P >> 1, with 0 shifted in at the MSB.
  - count<=count+1.
  - When count==WIDTH-1 the state becomes DONE on that same edge.
  - Latency: opdone==2'b11 observed after exactly WIDTH+1 rising edges, counting the start edge (65 for WIDTH=64).
- DONE:
  - Hold result and opdone=11 indefinitely.
  - opstart is ignored in DONE; no restart without a clear.
  - opclear=1: go IDLE, P<=0. result reads 0 and opdone reads 00 the next cycle.
- opclear during EXEC: abort at the next edge, go IDLE, P<=0, count<=0. No partial result is exposed as done.
- opstart during EXEC: ignored. Operands latched at start are used and input changes during EXEC have no effect.
- opstart and opclear high in the same cycle: clear wins in every state.
- Arithmetic: unsigned only. The product never exceeds 2*WIDTH bits, so no overflow flag. The carry bit P[2W] is always 0 after the final shift.
- Reset asserted mid-EXEC: immediate return to IDLE with all outputs at reset values. The next opstart behaves normally.
- result during EXEC is intermediate and undefined for consumers. Only opdone==11 qualifies it.

Test Plan:
- Reset, then opstart 1 cycle with A=3, B=5 -> opdone=10 for 64 cycles, then 11 at edge 65; result=15. Holds until opclear, then result=0 and opdone=00.
- A=B=2^64-1 -> result=128'hFFFFFFFFFFFFFFFE_0000000000000001 after 65 edges.
- A=0, B=12345 and separately A=7, B=0 -> opdone=11 one cycle after start; result=0.
- Start A=20, B=19 (factorial step 380):
  - opstart toggled at edge 10 with A=9, B=9 -> ignored; result=380 at edge 65.
  - opstart held high in DONE -> no restart.
- Start A=6, B=7, opclear at edge 30 -> IDLE next cycle, opdone=00, result=0. Restart with A=6, B=7 -> 42 after 65 edges.
- reset_n pulsed low mid-EXEC (asynchronously, between edges) -> outputs zero immediately. opstart and opclear high together -> stays IDLE, opdone=00.
